// File: rtl/saturn_bus_config_ctrl_if.sv
// Saturn bus configuration controller interface.
// Groups the command, decode and nibble-return signals of saturn_bus_config_ctrl.
// The optional o_conflict signal exists only when SATURN_BUS_CFG_CONFLICT_EN is defined.
// o_dbg_state exposes the per-device state machines (2 bits per device, device k at [2k+1:2k]).
// Handshake: a command is accepted on any clock edge where i_cmd_valid && i_clk_en;
// there is no ready, the controller always accepts, and o_cmd_done answers one cycle later.
interface saturn_bus_config_ctrl_if #(
    parameter int N_DEV = 4
);
    logic                 i_clk_en;
    logic                 i_cmd_valid;
    logic [1:0]           i_cmd;
    logic [19:0]          i_cmd_addr;
    logic                 o_cmd_done;
    logic [19:0]          o_id;
    logic                 i_addr_valid;
    logic [19:0]          i_addr;
    logic [N_DEV-1:0]     o_sel;
    logic                 o_hit;
    logic [4*N_DEV-1:0]   i_dev_nibbles;
    logic [3:0]           o_nibble;
    logic [2*N_DEV-1:0]   o_dbg_state;
`ifdef SATURN_BUS_CFG_CONFLICT_EN
    logic                 o_conflict;

    modport slave (
        input  i_clk_en, i_cmd_valid, i_cmd, i_cmd_addr, i_addr_valid, i_addr, i_dev_nibbles,
        output o_cmd_done, o_id, o_sel, o_hit, o_nibble, o_dbg_state, o_conflict
    );
    modport master (
        output i_clk_en, i_cmd_valid, i_cmd, i_cmd_addr, i_addr_valid, i_addr, i_dev_nibbles,
        input  o_cmd_done, o_id, o_sel, o_hit, o_nibble, o_dbg_state, o_conflict
    );
`else
    modport slave (
        input  i_clk_en, i_cmd_valid, i_cmd, i_cmd_addr, i_addr_valid, i_addr, i_dev_nibbles,
        output o_cmd_done, o_id, o_sel, o_hit, o_nibble, o_dbg_state
    );
    modport master (
        output i_clk_en, i_cmd_valid, i_cmd, i_cmd_addr, i_addr_valid, i_addr, i_dev_nibbles,
        input  o_cmd_done, o_id, o_sel, o_hit, o_nibble, o_dbg_state
    );
`endif
endinterface

// File: rtl/saturn_bus_config_ctrl.sv
// Saturn bus daisy-chain configuration controller and address decoder.
// Devices 1..N_DEV-1 walk UNCFG -> SIZED -> CFG via CONFIG commands along the chain;
// device 0 is the fixed firmware ROM at base 0 with mask ROM_MASK, lowest priority.
// Optional macro SATURN_BUS_CFG_CONFLICT_EN adds o_conflict (two or more non-ROM hits).
module saturn_bus_config_ctrl #(
    parameter int                  N_DEV    = 4,
    parameter logic [20*N_DEV-1:0] DEV_IDS  = {20'h00007, 20'h000F6, 20'h00005, 20'h00000},
    parameter logic [19:0]         ROM_MASK = 20'h80000
) (
    input logic                    i_clk,
    input logic                    i_reset,
    saturn_bus_config_ctrl_if.slave bus
);

    localparam int PTR_W = $clog2(N_DEV);

    localparam logic [1:0] CMD_RESET  = 2'd0;
    localparam logic [1:0] CMD_CONFIG = 2'd1;
    localparam logic [1:0] CMD_UNCNFG = 2'd2;

    typedef enum logic [1:0] {
        DEV_UNCFG = 2'd0,
        DEV_SIZED = 2'd1,
        DEV_CFG   = 2'd2
    } dev_state_e;

    dev_state_e         state_q [N_DEV];
    dev_state_e         state_d [N_DEV];
    logic [19:0]        mask_q  [N_DEV];
    logic [19:0]        mask_d  [N_DEV];
    logic [19:0]        base_q  [N_DEV];
    logic [19:0]        base_d  [N_DEV];
    logic [19:0]        id_q, id_d;
    logic               done_q;
    logic [N_DEV-1:0]   sel_q, sel_d;
    logic               hit_q, hit_d;
    logic [N_DEV-1:0]   hit_vec;
    logic [PTR_W-1:0]   ptr;
    logic               ptr_valid;
    logic               cmd_accept;
    logic               dec_accept;

    assign cmd_accept = bus.i_cmd_valid && bus.i_clk_en;
    assign dec_accept = bus.i_addr_valid && bus.i_clk_en;

    // Chain pointer: lowest-index non-ROM device that is not yet configured.
    always_comb begin
        ptr       = '0;
        ptr_valid = 1'b0;
        for (int k = N_DEV - 1; k >= 1; k--) begin
            if (state_q[k] != DEV_CFG) begin
                ptr       = PTR_W'(k);
                ptr_valid = 1'b1;
            end
        end
    end

    // Next-state logic for the device state machines and the C=ID result.
    always_comb begin
        for (int k = 0; k < N_DEV; k++) begin
            state_d[k] = state_q[k];
            mask_d[k]  = mask_q[k];
            base_d[k]  = base_q[k];
        end
        id_d = id_q;
        if (cmd_accept) begin
            case (bus.i_cmd)
                CMD_RESET: begin
                    for (int k = 1; k < N_DEV; k++) state_d[k] = DEV_UNCFG;
                end
                CMD_CONFIG: begin
                    // Only the chain-pointer device moves; with no pointer this is a no-op.
                    for (int k = 1; k < N_DEV; k++) begin
                        if (ptr_valid && ptr == PTR_W'(k)) begin
                            if (state_q[k] == DEV_UNCFG) begin
                                state_d[k] = DEV_SIZED;
                                mask_d[k]  = bus.i_cmd_addr;
                            end else begin
                                state_d[k] = DEV_CFG;
                                base_d[k]  = bus.i_cmd_addr & mask_q[k];
                            end
                        end
                    end
                end
                CMD_UNCNFG: begin
                    // Every configured device matching the address drops out, not just one.
                    for (int k = 1; k < N_DEV; k++) begin
                        if (state_q[k] == DEV_CFG && (bus.i_cmd_addr & mask_q[k]) == base_q[k])
                            state_d[k] = DEV_UNCFG;
                    end
                end
                default: begin
                    id_d = '0;
                    for (int k = 1; k < N_DEV; k++) begin
                        if (ptr_valid && ptr == PTR_W'(k)) id_d = DEV_IDS[20*k +: 20];
                    end
                end
            endcase
        end
    end

    // Device state registers and command result registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < N_DEV; k++) begin
                state_q[k] <= DEV_UNCFG;
                mask_q[k]  <= '0;
                base_q[k]  <= '0;
            end
            id_q   <= '0;
            done_q <= 1'b0;
        end else begin
            for (int k = 0; k < N_DEV; k++) begin
                state_q[k] <= state_d[k];
                mask_q[k]  <= mask_d[k];
                base_q[k]  <= base_d[k];
            end
            id_q   <= id_d;
            done_q <= cmd_accept;
        end
    end

    // Address decode against the pre-command state; highest hitting index wins.
    always_comb begin
        hit_vec    = '0;
        hit_vec[0] = (bus.i_addr & ROM_MASK) == 20'h00000;
        for (int k = 1; k < N_DEV; k++) begin
            hit_vec[k] = (state_q[k] == DEV_CFG) && ((bus.i_addr & mask_q[k]) == base_q[k]);
        end
        sel_d = '0;
        for (int k = 0; k < N_DEV; k++) begin
            if (hit_vec[k]) begin
                sel_d    = '0;
                sel_d[k] = 1'b1;
            end
        end
        hit_d = |hit_vec;
    end

    // Decode result registers; they hold between decode requests.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sel_q <= '0;
            hit_q <= 1'b0;
        end else if (dec_accept) begin
            sel_q <= sel_d;
            hit_q <= hit_d;
        end
    end

`ifdef SATURN_BUS_CFG_CONFLICT_EN
    logic [N_DEV-1:0] hit_hi;
    logic             conflict_q;

    // Two or more non-ROM hits: clearing the lowest set bit still leaves a bit set.
    assign hit_hi = hit_vec & ~N_DEV'(1);

    // Conflict flag registered alongside the select.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) conflict_q <= 1'b0;
        else if (dec_accept) conflict_q <= |(hit_hi & (hit_hi - N_DEV'(1)));
    end

    assign bus.o_conflict = conflict_q;
`endif

    // Nibble return mux; select is one-hot so an OR-reduction suffices.
    always_comb begin
        bus.o_nibble = 4'h0;
        for (int k = 0; k < N_DEV; k++) begin
            if (sel_q[k]) bus.o_nibble = bus.o_nibble | bus.i_dev_nibbles[4*k +: 4];
        end
    end

    // Debug view of the device state machines.
    always_comb begin
        bus.o_dbg_state = '0;
        for (int k = 0; k < N_DEV; k++) bus.o_dbg_state[2*k +: 2] = state_q[k];
    end

    assign bus.o_cmd_done = done_q;
    assign bus.o_id       = id_q;
    assign bus.o_sel      = sel_q;
    assign bus.o_hit      = hit_q;

endmodule

// File: tb/tb_saturn_bus_config_ctrl.sv
// Testbench for saturn_bus_config_ctrl with a behavioural reference model.
// Checks o_conflict as well when SATURN_BUS_CFG_CONFLICT_EN is defined.
module tb_saturn_bus_config_ctrl;

    localparam int N = 4;
    localparam logic [1:0] C_RESET = 2'd0, C_CONFIG = 2'd1, C_UNCNFG = 2'd2, C_CID = 2'd3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    saturn_bus_config_ctrl_if #(.N_DEV(N)) bus ();

    saturn_bus_config_ctrl #(.N_DEV(N)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus.slave)
    );

    // Reference model: device configuration as the spec describes it.
    int          m_state [N];   // 0 unconfigured, 1 sized, 2 configured
    logic [19:0] m_mask  [N];
    logic [19:0] m_base  [N];
    logic [19:0] m_id;
    logic [19:0] ids [N] = '{20'h00000, 20'h00005, 20'h000F6, 20'h00007};
    logic        exp_done;
    logic [N-1:0] exp_sel;
    logic        exp_hit;
    logic        exp_conf;

    function automatic int m_ptr();
        for (int k = 1; k < N; k++) if (m_state[k] != 2) return k;
        return 0;
    endfunction

    function automatic void m_reset();
        for (int k = 0; k < N; k++) begin m_state[k] = 0; m_mask[k] = 0; m_base[k] = 0; end
        m_id = 0; exp_done = 0; exp_sel = 0; exp_hit = 0; exp_conf = 0;
    endfunction

    function automatic void m_cmd(input logic [1:0] c, input logic [19:0] a);
        int p;
        p = m_ptr();
        case (c)
            C_RESET:  for (int k = 1; k < N; k++) m_state[k] = 0;
            C_CONFIG: if (p != 0) begin
                if (m_state[p] == 0) begin m_state[p] = 1; m_mask[p] = a; end
                else begin m_state[p] = 2; m_base[p] = a & m_mask[p]; end
            end
            C_UNCNFG: for (int k = 1; k < N; k++)
                if (m_state[k] == 2 && (a & m_mask[k]) == m_base[k]) m_state[k] = 0;
            default:  m_id = (p != 0) ? ids[p] : 20'h0;
        endcase
    endfunction

    function automatic void m_decode(input logic [19:0] a);
        int winner = -1;
        int count  = 0;
        if ((a & 20'h80000) == 20'h0) winner = 0;
        for (int k = 1; k < N; k++)
            if (m_state[k] == 2 && (a & m_mask[k]) == m_base[k]) begin winner = k; count++; end
        exp_sel = '0;
        if (winner >= 0) exp_sel[winner] = 1'b1;
        exp_hit  = (winner >= 0);
        exp_conf = (count >= 2);
    endfunction

    function automatic logic [3:0] exp_nibble();
        logic [4*N-1:0] n = bus.i_dev_nibbles;
        for (int k = 0; k < N; k++) if (exp_sel[k]) return n[4*k +: 4];
        return 4'h0;
    endfunction

    // Driver: presents one cycle of inputs at the negedge, updates the model,
    // and returns 1 time unit after the sampling edge.
    task automatic drive_cycle(input logic en, input logic cv, input logic [1:0] c,
                               input logic [19:0] ca, input logic av, input logic [19:0] aa);
        logic [31:0] r;
        @(negedge clk);
        r = $urandom;
        bus.i_dev_nibbles = r[4*N-1:0];
        bus.i_clk_en = en; bus.i_cmd_valid = cv; bus.i_cmd = c; bus.i_cmd_addr = ca;
        bus.i_addr_valid = av; bus.i_addr = aa;
        exp_done = en && cv;
        if (en && av) m_decode(aa);
        if (en && cv) m_cmd(c, ca);
        @(posedge clk);
        #1;
        bus.i_cmd_valid = 1'b0; bus.i_addr_valid = 1'b0; bus.i_clk_en = 1'b1;
    endtask

    task automatic send_cmd(input logic [1:0] c, input logic [19:0] a);
        drive_cycle(1'b1, 1'b1, c, a, 1'b0, 20'h0);
    endtask

    task automatic send_dec(input logic [19:0] a);
        drive_cycle(1'b1, 1'b0, C_RESET, 20'h0, 1'b1, a);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        m_reset();
        total++; if (bus.o_cmd_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.o_cmd_done); end
        total++; if (bus.o_id !== 20'h0) begin bad++; $display("FAIL reset_id got=%h exp=00000", bus.o_id); end
        total++; if (bus.o_sel !== 4'b0000 || bus.o_hit !== 1'b0) begin bad++; $display("FAIL reset_sel got=%b/%b exp=0000/0", bus.o_sel, bus.o_hit); end
        total++; if (bus.o_nibble !== 4'h0) begin bad++; $display("FAIL reset_nibble got=%h exp=0", bus.o_nibble); end
`ifdef SATURN_BUS_CFG_CONFLICT_EN
        total++; if (bus.o_conflict !== 1'b0) begin bad++; $display("FAIL reset_conflict got=%b exp=0", bus.o_conflict); end
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_cid_first();
        send_cmd(C_CID, 20'h0);
        total++; if (bus.o_cmd_done !== 1'b1) begin bad++; $display("FAIL cid_done got=%b exp=1", bus.o_cmd_done); end
        total++; if (bus.o_id !== 20'h00005) begin bad++; $display("FAIL cid_first got=%h exp=00005", bus.o_id); end
        drive_cycle(1'b1, 1'b0, C_RESET, 20'h0, 1'b0, 20'h0);
        total++; if (bus.o_cmd_done !== 1'b0) begin bad++; $display("FAIL done_one_cycle got=%b exp=0", bus.o_cmd_done); end
        total++; if (bus.o_id !== 20'h00005) begin bad++; $display("FAIL id_hold got=%h exp=00005", bus.o_id); end
    endtask

    task automatic test_config_decode();
        send_cmd(C_CONFIG, 20'hC0000);
        total++; if (bus.o_cmd_done !== 1'b1) begin bad++; $display("FAIL cfg1_done got=%b exp=1", bus.o_cmd_done); end
        // Decode in the same cycle as the second CONFIG sees the pre-command state.
        drive_cycle(1'b1, 1'b1, C_CONFIG, 20'h81234, 1'b1, 20'h81234);
        total++; if (bus.o_hit !== 1'b0 || bus.o_sel !== 4'b0000) begin bad++; $display("FAIL same_cycle_dec got=%b/%b exp=0000/0", bus.o_sel, bus.o_hit); end
        send_dec(20'h81234);
        total++; if (bus.o_sel !== 4'b0010 || bus.o_hit !== 1'b1) begin bad++; $display("FAIL dec_dev1 got=%b/%b exp=0010/1", bus.o_sel, bus.o_hit); end
        total++; if (bus.o_nibble !== bus.i_dev_nibbles[7:4]) begin bad++; $display("FAIL nib_dev1 got=%h exp=%h", bus.o_nibble, bus.i_dev_nibbles[7:4]); end
        send_dec(20'h01234);
        total++; if (bus.o_sel !== 4'b0001) begin bad++; $display("FAIL dec_rom got=%b exp=0001", bus.o_sel); end
        total++; if (bus.o_nibble !== bus.i_dev_nibbles[3:0]) begin bad++; $display("FAIL nib_rom got=%h exp=%h", bus.o_nibble, bus.i_dev_nibbles[3:0]); end
        send_dec(20'hC0000);
        total++; if (bus.o_hit !== 1'b0 || bus.o_nibble !== 4'h0) begin bad++; $display("FAIL dec_none got=%b/%h exp=0/0", bus.o_hit, bus.o_nibble); end
    endtask

    task automatic test_overlap_uncnfg();
        for (int d = 2; d <= 3; d++) begin
            send_cmd(C_CONFIG, 20'hC0000);
            send_cmd(C_CONFIG, 20'h80010);
        end
        send_dec(20'h80010);
        total++; if (bus.o_sel !== 4'b1000 || bus.o_hit !== 1'b1) begin bad++; $display("FAIL overlap_sel got=%b exp=1000", bus.o_sel); end
`ifdef SATURN_BUS_CFG_CONFLICT_EN
        total++; if (bus.o_conflict !== 1'b1) begin bad++; $display("FAIL overlap_conflict got=%b exp=1", bus.o_conflict); end
`endif
        send_cmd(C_UNCNFG, 20'h80010);
        total++; if (bus.o_cmd_done !== 1'b1) begin bad++; $display("FAIL uncnfg_done got=%b exp=1", bus.o_cmd_done); end
        send_cmd(C_CID, 20'h0);
        total++; if (bus.o_id !== 20'h00005) begin bad++; $display("FAIL uncnfg_cid got=%h exp=00005", bus.o_id); end
        send_dec(20'h80010);
        total++; if (bus.o_hit !== 1'b0) begin bad++; $display("FAIL uncnfg_dec got=%b exp=0", bus.o_hit); end
    endtask

    task automatic test_all_cfg();
        send_cmd(C_CONFIG, 20'hF0000); send_cmd(C_CONFIG, 20'h1ABCD);
        send_cmd(C_CONFIG, 20'hF0000); send_cmd(C_CONFIG, 20'h2ABCD);
        send_cmd(C_CONFIG, 20'hFF000); send_cmd(C_CONFIG, 20'h12FFF);
        send_cmd(C_CID, 20'h0);
        total++; if (bus.o_id !== 20'h00000) begin bad++; $display("FAIL allcfg_cid got=%h exp=00000", bus.o_id); end
        send_cmd(C_CONFIG, 20'h12345);
        total++; if (bus.o_cmd_done !== 1'b1) begin bad++; $display("FAIL allcfg_noop_done got=%b exp=1", bus.o_cmd_done); end
        send_dec(20'h12345);
        total++; if (bus.o_sel !== 4'b1000) begin bad++; $display("FAIL allcfg_dec12 got=%b exp=1000", bus.o_sel); end
        send_dec(20'h2F00F);
        total++; if (bus.o_sel !== 4'b0100) begin bad++; $display("FAIL allcfg_dec2 got=%b exp=0100", bus.o_sel); end
        send_dec(20'h1F000);
        total++; if (bus.o_sel !== 4'b0010) begin bad++; $display("FAIL allcfg_dec1 got=%b exp=0010", bus.o_sel); end
        send_cmd(C_RESET, 20'h0);
        send_cmd(C_CID, 20'h0);
        total++; if (bus.o_id !== 20'h00005) begin bad++; $display("FAIL resetcmd_cid got=%h exp=00005", bus.o_id); end
        send_dec(20'h12345);
        total++; if (bus.o_sel !== 4'b0001) begin bad++; $display("FAIL resetcmd_dec got=%b exp=0001", bus.o_sel); end
    endtask

    task automatic test_reset_mid_command();
        send_cmd(C_CONFIG, 20'hC0000);
        @(negedge clk);
        bus.i_cmd_valid = 1'b1; bus.i_cmd = C_CONFIG; bus.i_cmd_addr = 20'h81234;
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        bus.i_cmd_valid = 1'b0;
        m_reset();
        #2 rst = 1'b0;
        total++; if (bus.o_cmd_done !== 1'b0) begin bad++; $display("FAIL midreset_done got=%b exp=0", bus.o_cmd_done); end
        drive_cycle(1'b1, 1'b0, C_RESET, 20'h0, 1'b0, 20'h0);
        total++; if (bus.o_cmd_done !== 1'b0) begin bad++; $display("FAIL midreset_done2 got=%b exp=0", bus.o_cmd_done); end
        // Device 1 must be unconfigured again: one CONFIG only sizes it.
        send_cmd(C_CONFIG, 20'hC0000);
        send_dec(20'h81234);
        total++; if (bus.o_hit !== 1'b0) begin bad++; $display("FAIL midreset_state got=%b exp=0", bus.o_hit); end
        send_cmd(C_CID, 20'h0);
        total++; if (bus.o_id !== 20'h00005) begin bad++; $display("FAIL midreset_cid got=%h exp=00005", bus.o_id); end
    endtask

    task automatic test_clk_en();
        logic [N-1:0] sel_before;
        send_cmd(C_CONFIG, 20'h81234);
        send_dec(20'h81234);
        sel_before = exp_sel;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 1'b1, C_UNCNFG, 20'h81234, 1'b1, 20'h01234);
            total++; if (bus.o_cmd_done !== 1'b0) begin bad++; $display("FAIL clken_done got=%b exp=0", bus.o_cmd_done); end
            total++; if (bus.o_sel !== sel_before) begin bad++; $display("FAIL clken_sel_hold got=%b exp=%b", bus.o_sel, sel_before); end
        end
        send_dec(20'h81234);
        total++; if (bus.o_sel !== 4'b0010) begin bad++; $display("FAIL clken_state got=%b exp=0010", bus.o_sel); end
    endtask

    task automatic test_random();
        logic [19:0] pool [8];
        logic [1:0]  c;
        int          r;
        pool = '{20'hC0000, 20'h80000, 20'hF0000, 20'hA5000, 20'h81234, 20'h80010, 20'h01234, 20'h00000};
        send_cmd(C_RESET, 20'h0);
        for (int i = 0; i < 400; i++) begin
            logic [19:0] ca, aa;
            r  = $urandom_range(0, 9);
            c  = (r == 0) ? C_RESET : (r <= 4) ? C_CONFIG : (r <= 6) ? C_UNCNFG : C_CID;
            ca = ($urandom_range(0, 7) == 0) ? 20'($urandom) : pool[$urandom_range(0, 7)];
            aa = ($urandom_range(0, 7) == 0) ? 20'($urandom) : pool[$urandom_range(0, 7)];
            drive_cycle($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1, c, ca,
                        $urandom_range(0, 2) != 0, aa);
            total++; if (bus.o_cmd_done !== exp_done) begin bad++; $display("FAIL rnd_done i=%0d got=%b exp=%b", i, bus.o_cmd_done, exp_done); end
            total++; if (bus.o_id !== m_id) begin bad++; $display("FAIL rnd_id i=%0d got=%h exp=%h", i, bus.o_id, m_id); end
            total++; if (bus.o_sel !== exp_sel || bus.o_hit !== exp_hit) begin bad++; $display("FAIL rnd_sel i=%0d got=%b/%b exp=%b/%b", i, bus.o_sel, bus.o_hit, exp_sel, exp_hit); end
            total++; if (bus.o_nibble !== exp_nibble()) begin bad++; $display("FAIL rnd_nibble i=%0d got=%h exp=%h", i, bus.o_nibble, exp_nibble()); end
`ifdef SATURN_BUS_CFG_CONFLICT_EN
            total++; if (bus.o_conflict !== exp_conf) begin bad++; $display("FAIL rnd_conflict i=%0d got=%b exp=%b", i, bus.o_conflict, exp_conf); end
`endif
        end
    endtask

    initial begin
        bus.i_clk_en = 1'b1; bus.i_cmd_valid = 1'b0; bus.i_cmd = 2'd0; bus.i_cmd_addr = 20'h0;
        bus.i_addr_valid = 1'b0; bus.i_addr = 20'h0; bus.i_dev_nibbles = '0;
        m_reset();
        test_reset();
        test_cid_first();
        test_config_decode();
        test_overlap_uncnfg();
        test_all_cfg();
        test_reset_mid_command();
        test_clk_en();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
